// File: rtl/mdr_ctrl.sv
// Sequencer for the iterative multiply/divide/sqrt datapath: operand loads, init, per-iteration steps.
// Outputs decode registered state except ld_x/ld_y, which are gated by load in the same cycle.
module mdr_ctrl #(
  parameter int DW    = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             load,
  input  logic             y_is_zero,
  output logic             ld_x,
  output logic             ld_y,
  output logic             dp_init,
  output logic             step,
  output logic [CNT_W-1:0] iter,
  output logic [1:0]       op_q,
  output logic             busy,
  output logic             ready,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_X    = 3'd1,
    LOAD_Y    = 3'd2,
    INIT      = 3'd3,
    PROCESING = 3'd4,
    READY     = 3'd5
  } state_e;

  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_BAD  = 2'b11;

  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(DW / 2 - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] iter_d;
  logic [CNT_W-1:0] last_iter;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      err_q   <= 1'b0;
      iter    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      err_q   <= err_d;
      iter    <= iter_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    iter_d    = iter;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    dp_init   = 1'b0;
    step      = 1'b0;
    busy      = 1'b0;
    ready     = (state_q == READY);
    error     = (state_q == READY) && err_q;
    last_iter = (op_q == OP_SQRT) ? LAST_HALF : LAST_FULL;

    case (state_q)
      // READY accepts a new request exactly like IDLE; a simultaneous load is dropped.
      IDLE, READY: begin
        if (start) begin
          op_d = op;
          if (op == OP_BAD) begin
            err_d   = 1'b1;
            state_d = READY;
          end else begin
            err_d   = 1'b0;
            state_d = LOAD_X;
          end
        end
      end
      LOAD_X: begin
        busy = 1'b1;
        ld_x = load;
        if (load) state_d = (op_q == OP_SQRT) ? INIT : LOAD_Y;
      end
      LOAD_Y: begin
        busy = 1'b1;
        ld_y = load;
        if (load) state_d = INIT;
      end
      INIT: begin
        busy    = 1'b1;
        dp_init = 1'b1;
        iter_d  = '0;
        if (op_q == OP_DIV && y_is_zero) begin
          err_d   = 1'b1;
          state_d = READY;
        end else begin
          state_d = PROCESING;
        end
      end
      PROCESING: begin
        busy = 1'b1;
        step = 1'b1;
        // iter freezes on the final index so the display sees the last step count.
        if (iter == last_iter) state_d = READY;
        else                   iter_d  = iter + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdr_ctrl.sv
// Self-checking bench for mdr_ctrl: directed scenarios plus randomized operations
// checked against a cycle schedule derived from the operation timing rules.
module tb_mdr_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, load, y_is_zero;
  logic [1:0] op;
  logic       ld_x, ld_y, dp_init, step, busy, ready, error;
  logic [4:0] iter;
  logic [1:0] op_q;

  int checks   = 0;
  int failures = 0;
  logic [4:0] m_iter = '0;

  mdr_ctrl #(.DW(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .load(load), .y_is_zero(y_is_zero),
    .ld_x(ld_x), .ld_y(ld_y), .dp_init(dp_init), .step(step), .iter(iter),
    .op_q(op_q), .busy(busy), .ready(ready), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ex, ey, ei, es,
                            input logic [4:0] eit, input logic [1:0] eop,
                            input logic eb, er, ee);
    logic [13:0] obs, exp;
    @(negedge clk);
    obs = {ld_x, ld_y, dp_init, step, iter, op_q, busy, ready, error};
    exp = {ex, ey, ei, es, eit, eop, eb, er, ee};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (ldx,ldy,init,step,iter,opq,busy,ready,err)",
             tag, obs, exp);
    end
  endtask

  // Random activity on inputs the controller must ignore in the current phase.
  task automatic noise(input bit allow_load);
    start     = 1'($urandom_range(0, 1));
    op        = 2'($urandom_range(0, 3));
    y_is_zero = 1'($urandom_range(0, 1));
    load      = allow_load ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic quiet();
    start = 1'b0; load = 1'b0; y_is_zero = 1'b0; op = 2'b00;
  endtask

  // One full operation from IDLE/READY. gx/gy: idle cycles before each operand load.
  task automatic do_op(input logic [1:0] o, input int gx, input int gy,
                       input bit yz, input bit sim_load);
    int n;
    start = 1'b1; op = o; load = sim_load; y_is_zero = 1'b0;
    tick();
    quiet();
    if (o == 2'b11) begin
      expect_out("bad_op_ready", 0, 0, 0, 0, m_iter, o, 0, 1, 1);
      tick();
      return;
    end
    for (int i = 0; i < gx; i++) begin
      noise(1'b0);
      expect_out("wait_x", 0, 0, 0, 0, m_iter, o, 1, 0, 0);
      tick();
    end
    noise(1'b0); load = 1'b1;
    expect_out("ld_x", 1, 0, 0, 0, m_iter, o, 1, 0, 0);
    tick();
    if (o != 2'b10) begin
      for (int i = 0; i < gy; i++) begin
        noise(1'b0);
        expect_out("wait_y", 0, 0, 0, 0, m_iter, o, 1, 0, 0);
        tick();
      end
      noise(1'b0); load = 1'b1;
      expect_out("ld_y", 0, 1, 0, 0, m_iter, o, 1, 0, 0);
      tick();
    end
    noise(1'b1); y_is_zero = yz;
    expect_out("dp_init", 0, 0, 1, 0, m_iter, o, 1, 0, 0);
    tick();
    m_iter = '0;
    if (o == 2'b01 && yz) begin
      quiet();
      expect_out("div0_ready", 0, 0, 0, 0, m_iter, o, 0, 1, 1);
      tick();
      return;
    end
    n = (o == 2'b10) ? 8 : 16;
    for (int i = 0; i < n; i++) begin
      noise(1'b1);
      expect_out("step", 0, 0, 0, 1, 5'(i), o, 1, 0, 0);
      tick();
    end
    m_iter = 5'(n - 1);
    quiet();
    expect_out("done_ready", 0, 0, 0, 0, m_iter, o, 0, 1, 0);
    tick();
    expect_out("ready_hold", 0, 0, 0, 0, m_iter, o, 0, 1, 0);
    tick();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    tick();
    tick();
    expect_out("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Directed: MUL, DIV by zero, SQRT, invalid op then restart from READY, DIV normal.
    do_op(2'b00, 1, 2, 1'b0, 1'b0);
    do_op(2'b01, 0, 0, 1'b1, 1'b0);
    do_op(2'b10, 2, 0, 1'b0, 1'b1);
    do_op(2'b11, 0, 0, 1'b0, 1'b0);
    do_op(2'b00, 0, 1, 1'b0, 1'b0);
    do_op(2'b01, 1, 1, 1'b0, 1'b0);

    // Reset held for two cycles in the middle of PROCESING.
    start = 1'b1; op = 2'b00; tick(); quiet();
    load = 1'b1; tick(); tick(); load = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1; load = 1'b1;
    tick();
    expect_out("rst_mid_op", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0; load = 1'b1;
    expect_out("rst_released", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    load = 1'b0;
    m_iter = '0;
    for (int i = 0; i < 3; i++) begin
      expect_out("idle_after_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end

    for (int t = 0; t < 30; t++) begin
      do_op(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
